// File: rtl/obj_line_scanner_if.sv
// Memory-side bundle of the object line scanner: object RAM read port,
// graphics ROM request/acknowledge and line buffer write port.
interface obj_line_scanner_if #(
  parameter int ROM_AW = 22,
  parameter int X_W    = 10
);
  logic              obj_busy;
  logic [10:0]       obj_addr;
  logic [15:0]       obj_data;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_req;
  logic              rom_ack;
  logic [63:0]       rom_data;
  logic              lb_we;
  logic              lb_bank;
  logic [X_W-1:0]    lb_addr;
  logic [11:0]       lb_data;

  // scanner side
  modport master (
    output obj_addr, rom_addr, rom_req, lb_we, lb_bank, lb_addr, lb_data,
    input  obj_busy, obj_data, rom_ack, rom_data
  );

  // memory / line buffer side
  modport slave (
    input  obj_addr, rom_addr, rom_req, lb_we, lb_bank, lb_addr, lb_data,
    output obj_busy, obj_data, rom_ack, rom_data
  );
endinterface

// File: rtl/obj_line_scanner.sv
// Per-scanline sprite renderer: walks object RAM, fetches one 16-pixel
// 4bpp graphics row per sprite that intersects the target line, and writes
// its opaque pixels into the inactive half of the double line buffer.
module obj_line_scanner #(
  parameter int NUM_OBJ = 512,
  parameter int ROM_AW  = 22,
  parameter int X_W     = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       line_start,
  input  logic [8:0] line,
  obj_line_scanner_if.master bus,
  output logic       done,
  output logic       overrun
);

  localparam logic [8:0] LAST_IDX = 9'(NUM_OBJ - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, ROM_WAIT, DRAW, NEXT} state_t;

  state_t r_state, w_nstate;

  // scan context
  logic [8:0]  r_line;
  logic        r_bank;
  logic [8:0]  r_idx;
  logic [2:0]  r_k;       // next object word to present (4 = all presented)
  logic        r_pend;    // a word read was issued last ce-cycle
  logic [1:0]  r_pk;      // which word that read was for

  // current object entry
  logic [8:0]  r_y;
  logic [1:0]  r_hcode;
  logic [15:0] r_code;
  logic [6:0]  r_color;
  logic        r_prio;
  logic        r_flipx;
  logic        r_flipy;
  logic [9:0]  r_x;

  // ROM / draw
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_rom_req;
  logic [63:0]       r_pix;
  logic [3:0]        r_i;
  logic              r_we;
  logic [X_W-1:0]    r_lb_addr;
  logic [11:0]       r_lb_data;
  logic              r_done;
  logic              r_overrun;

  // hit test and row address
  logic [8:0]        w_row;
  logic [8:0]        w_hpx;
  logic              w_hit;
  logic [5:0]        w_r;
  logic [ROM_AW-5:0] w_tile;
  logic [ROM_AW-1:0] w_rom_addr;

  // pixel selection for the draw slot being loaded
  logic [63:0]    w_src;
  logic [3:0]     w_ni;
  logic [3:0]     w_n;
  logic [3:0]     w_pix;
  logic [X_W-1:0] w_xa;

  // Height code to pixel count; codes 2 and 3 are deliberately non-monotonic.
  always_comb begin
    w_hpx = 9'd16;
    case (r_hcode)
      2'd0: w_hpx = 9'd16;
      2'd1: w_hpx = 9'd32;
      2'd2: w_hpx = 9'd64;
      2'd3: w_hpx = 9'd48;
      default: w_hpx = 9'd16;
    endcase
  end

  // Row within the sprite wraps mod 512 so sprites straddling y=511 still hit.
  assign w_row      = r_line - r_y;
  assign w_hit      = (w_row < w_hpx);
  assign w_r        = r_flipy ? 6'(w_hpx - 9'd1 - w_row) : w_row[5:0];
  assign w_tile     = (ROM_AW-4)'(r_code) + (ROM_AW-4)'(w_r[5:4]);
  assign w_rom_addr = {w_tile, w_r[3:0]};

  // Slot 0 is loaded straight from the ROM bus on ack, later slots from the latch.
  assign w_src = (r_state == ROM_WAIT) ? bus.rom_data : r_pix;
  assign w_ni  = (r_state == ROM_WAIT) ? 4'd0 : r_i + 4'd1;
  assign w_n   = r_flipx ? ~w_ni : w_ni;
  assign w_pix = w_src[{w_n, 2'b00} +: 4];
  assign w_xa  = X_W'(r_x) + X_W'(w_ni);

  // Next-state logic; line_start overrides everything.
  always_comb begin
    w_nstate = r_state;
    if (line_start) begin
      w_nstate = FETCH;
    end else begin
      case (r_state)
        IDLE:     w_nstate = IDLE;
        FETCH:    if (r_k == 3'd4) w_nstate = CHECK;
        CHECK:    w_nstate = w_hit ? ROM_WAIT : NEXT;
        ROM_WAIT: if (bus.rom_ack) w_nstate = DRAW;
        DRAW:     if (r_i == 4'd15) w_nstate = NEXT;
        NEXT:     w_nstate = (r_idx == LAST_IDX) ? IDLE : FETCH;
        default:  w_nstate = IDLE;
      endcase
    end
  end

  // State register, advanced only on enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_state <= IDLE;
    else if (ce)   r_state <= w_nstate;
  end

  // Datapath: object word capture, ROM request, draw slot loading.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line     <= '0;
      r_bank     <= 1'b0;
      r_idx      <= '0;
      r_k        <= '0;
      r_pend     <= 1'b0;
      r_pk       <= '0;
      r_y        <= '0;
      r_hcode    <= '0;
      r_code     <= '0;
      r_color    <= '0;
      r_prio     <= 1'b0;
      r_flipx    <= 1'b0;
      r_flipy    <= 1'b0;
      r_x        <= '0;
      r_rom_addr <= '0;
      r_rom_req  <= 1'b0;
      r_pix      <= '0;
      r_i        <= '0;
      r_we       <= 1'b0;
      r_lb_addr  <= '0;
      r_lb_data  <= '0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (ce) begin
      r_overrun <= 1'b0;
      if (line_start) begin
        r_line    <= line;
        r_bank    <= line[0];
        r_idx     <= '0;
        r_k       <= '0;
        r_pend    <= 1'b0;
        r_done    <= 1'b0;
        r_rom_req <= 1'b0;
        r_we      <= 1'b0;
        r_overrun <= (r_state != IDLE);
      end else begin
        case (r_state)
          FETCH: begin
            // Data answers the read issued one ce-cycle earlier, even if
            // obj_busy rose meanwhile; busy only blocks issuing a new read.
            if (r_pend) begin
              case (r_pk)
                2'd0: begin r_y <= bus.obj_data[8:0]; r_hcode <= bus.obj_data[10:9]; end
                2'd1: r_code <= bus.obj_data;
                2'd2: begin
                  r_color <= bus.obj_data[6:0];
                  r_prio  <= bus.obj_data[7];
                  r_flipx <= bus.obj_data[8];
                  r_flipy <= bus.obj_data[9];
                end
                default: r_x <= bus.obj_data[9:0];
              endcase
            end
            if (r_k != 3'd4 && !bus.obj_busy) begin
              r_pend <= 1'b1;
              r_pk   <= r_k[1:0];
              r_k    <= r_k + 3'd1;
            end else begin
              r_pend <= 1'b0;
            end
          end
          CHECK: begin
            if (w_hit) begin
              r_rom_addr <= w_rom_addr;
              r_rom_req  <= 1'b1;
            end
          end
          ROM_WAIT: begin
            if (bus.rom_ack) begin
              r_rom_req <= 1'b0;
              r_pix     <= bus.rom_data;
              r_i       <= '0;
              r_we      <= (w_pix != 4'd0);
              r_lb_addr <= w_xa;
              r_lb_data <= {r_prio, r_color, w_pix};
            end
          end
          DRAW: begin
            if (r_i == 4'd15) begin
              r_we <= 1'b0;
            end else begin
              r_i       <= r_i + 4'd1;
              r_we      <= (w_pix != 4'd0);
              r_lb_addr <= w_xa;
              r_lb_data <= {r_prio, r_color, w_pix};
            end
          end
          NEXT: begin
            // NEXT doubles as word-0 read slot of the following entry,
            // keeping a missed entry at six ce-cycles.
            if (r_idx == LAST_IDX) begin
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 9'd1;
              if (!bus.obj_busy) begin
                r_pend <= 1'b1;
                r_pk   <= 2'd0;
                r_k    <= 3'd1;
              end else begin
                r_pend <= 1'b0;
                r_k    <= 3'd0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.obj_addr = (r_state == NEXT) ? {r_idx + 9'd1, 2'b00} : {r_idx, r_k[1:0]};
  assign bus.rom_addr = r_rom_addr;
  assign bus.rom_req  = r_rom_req;
  assign bus.lb_we    = r_we & ce;
  assign bus.lb_bank  = r_bank;
  assign bus.lb_addr  = r_lb_addr;
  assign bus.lb_data  = r_lb_data;
  assign done         = r_done;
  assign overrun      = r_overrun;

endmodule

// File: doc/obj_line_scanner.md
Name: obj_line_scanner

Overview:
- Per-scanline sprite renderer directly downstream of the GA21 object copier.
- Walks object RAM (512 entries × 4 words, in the layout GA21 writes) for the line being prepared.
- Fetches one 16-pixel, 4bpp row of graphics ROM per intersecting sprite and writes opaque pixels into the inactive half of an external double line buffer.

Parameters:
NUM_OBJ, 512, object entries scanned per line (power of two, ≤512)
ROM_AW, 22, graphics ROM address width (word = 64 bits = 16 px × 4bpp)
X_W, 10, line buffer x address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; all state advances only when ce=1
line_start  in  1  one-cycle pulse, begin preparing line `line`
line  in  9  target scanline (vertical coordinate, same space as obj y)
obj_busy  in  1  GA21 is writing object RAM; scanner must not read
obj_addr  out  11  {idx[8:0], word[1:0]} read address
obj_data  in  16  object RAM data, valid the ce-cycle after obj_addr
rom_addr  out  ROM_AW  graphics row address
rom_req  out  1  level request, held until rom_ack
rom_ack  in  1  one-cycle acknowledge, rom_data valid same cycle
rom_data  in  64  pixel n = rom_data[4n+3:4n], n=0 leftmost
lb_we  out  1  line buffer write strobe
lb_bank  out  1  bank being written = line[0] latched at line_start
lb_addr  out  X_W  pixel x
lb_data  out  12  {prio, color[6:0], pix[3:0]}
done  out  1  high while IDLE after a completed line
overrun  out  1  one-cycle pulse when line_start aborts an unfinished line

Behaviour:
- Reset (async, reset_n=0): state IDLE; obj_addr=0, rom_req=0, rom_addr=0, lb_we=0, lb_addr=0, lb_data=0, lb_bank=0, done=0, overrun=0.
- Object word layout:
  - w0: [8:0] y; [10:9] height code (0→16, 1→32, 3→48, 2→64 px); [15:13] layer (ignored).
  - w1: tile code.
  - w2: [6:0] color, [7] prio, [8] flipx, [9] flipy.
  - w3: [9:0] x.
- States: IDLE, FETCH, CHECK, ROM_WAIT, DRAW, NEXT.
- line_start (any state, ce=1):
  - Latch line and lb_bank=line[0]; idx=0; done=0; enter FETCH.
  - If the state was not IDLE, pulse overrun and drop any pending rom_req the same cycle.
- FETCH: 5-cycle sub-counter k=0..4.
  - k<4: obj_addr={idx,k}.
  - k>0: capture word k-1.
  - While obj_busy=1, the counter holds and no address changes.
  - After k=4 → CHECK.
- CHECK: row = (line − y) mod 512, 9-bit wrap.
  - Hit iff row < height_px.
  - Miss → NEXT.
  - Hit:
    - r = flipy ? height_px−1−row : row.
    - rom_addr = ((code + r[5:4]) << 4) | r[3:0], truncated to ROM_AW.
    - Assert rom_req → ROM_WAIT.
- ROM_WAIT: on rom_ack, latch rom_data, deassert rom_req next cycle, enter DRAW with i=0. rom_req stays stable until ack.
- DRAW: 16 cycles, i=0..15.
  - n = flipx ? 15−i : i.
  - lb_addr = (x + i) mod 2^X_W.
  - lb_data = {prio, color, pix_n}.
  - lb_we = (pix_n != 0); transparent pixel 0 is never written.
  - After i=15 → NEXT.
- NEXT:
  - If idx = NUM_OBJ−1 → IDLE with done=1.
  - Else idx+1 → FETCH.
- Draw order is idx ascending, so a later entry overwrites an earlier one at the same x.
- lb_we is a single-cycle strobe and is 0 in every state except DRAW.
- ce=0 freezes all state and outputs. lb_we is held low when ce=0.
- Reset mid-operation returns to IDLE immediately; rom_req drops asynchronously.
- Worst-case line: 512 × 6 + hits × (17 + ROM latency) ce-cycles. The caller sizes the line period accordingly; overrun reports violations.

Test Plan:
- All entries y=0x1F0 (off-line), line_start line=0x20 → no rom_req, no lb_we; done high after 512×6+1 ce-cycles.
- Entry 0: y=0x10, h=0, code=0x100, x=0x40, color=5; line=0x13; ROM returns 0x...0021 (pix0=1, pix1=2, rest 0) → rom_addr=0x1003; lb_we only at x=0x40 (data {0,5,1}) and 0x41 (data {0,5,2}).
- Same entry with flipx=1, flipy=1 → rom_addr=0x100C; pix0 written at x=0x4F.
- Height code 2, y=0x1F8, line=0x028 (row=0x30, wrap) → hit; rom_addr=(0x100+3)<<4 | 0 = 0x1030.
- Entries 3 and 7 both at x=0x80, opaque → final write at 0x80 carries entry 7's color.
- obj_busy held 20 cycles during FETCH → obj_addr frozen, no reads skipped. line_start mid-DRAW → overrun pulse, lb_we stops, scan restarts at idx 0.
